// File: rtl/num_counter_pkg.sv
// ============================================================================
// Module      : num_counter_pkg
// Description : Shared width and count type for num_counter and the FSMs
//               that compute its load values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package num_counter_pkg;

    localparam int COUNTER_W = 16;

    typedef logic [COUNTER_W-1:0] count_t;

endpackage : num_counter_pkg

`default_nettype wire

// File: rtl/num_counter.sv
// ============================================================================
// Module      : num_counter
// Description : Loadable saturating down-counter with zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module num_counter
    import num_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inVal,
    input  logic             dec,
    output logic             isZero,
    output logic [WIDTH-1:0] count
);

    generate
        if (WIDTH < 1) begin : g_width_check
            $fatal(1, "num_counter: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);

    // Decrement is gated by zero detect so the count saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= inVal;
        end else if (dec && !w_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign isZero = w_zero;
    assign count  = r_cnt;

`ifndef SYNTHESIS
    logic r_chk_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_armed <= 1'b1;
        end
    end

    a_no_underflow : assert property (@(posedge clk)
        (r_chk_armed && !rst && w_zero) |=> (r_cnt == '0))
        else $error("num_counter: count wrapped below zero");

    a_zero_consistent : assert property (@(posedge clk)
        r_chk_armed |-> (isZero == (count == '0)))
        else $error("num_counter: isZero disagrees with count");

    a_no_increase : assert property (@(posedge clk)
        (r_chk_armed && !rst) |=> (r_cnt <= $past(r_cnt)))
        else $error("num_counter: count increased without reset");
`endif

endmodule : num_counter

`default_nettype wire

// File: tb/tb_num_counter.sv
// ============================================================================
// Module      : tb_num_counter
// Description : Scoreboard bench for num_counter: directed plan plus random
//               traffic against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_num_counter;
    import num_counter_pkg::*;

    localparam int W = COUNTER_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dec = 1'b0;
    logic [W-1:0] inVal = '0;
    logic         isZero;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    num_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .inVal  (inVal),
        .dec    (dec),
        .isZero (isZero),
        .count  (count)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         zero;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    longint model  = 0;

    // Reference: reset loads, otherwise decrement clamped at zero.
    task automatic step(input logic r, input logic d, input logic [W-1:0] v);
        @(negedge clk);
        rst   = r;
        dec   = d;
        inVal = v;
        @(posedge clk);
        if (r)
            model = longint'(v);
        else if (d)
            model = (model > 0) ? model - 1 : 0;
        sb_q.push_back('{cnt: W'(model), zero: (model == 0)});
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (count !== mon_e.cnt) begin
                errors++;
                $display("FAIL count: got %0h expected %0h at %0t", count, mon_e.cnt, $time);
            end
            checks++;
            if (isZero !== mon_e.zero) begin
                errors++;
                $display("FAIL isZero: got %0b expected %0b at %0t", isZero, mon_e.zero, $time);
            end
        end
    end

    initial begin
        // Reset load and hold
        step(1'b1, 1'b0, W'(5));
        step(1'b0, 1'b0, W'(5));
        step(1'b0, 1'b0, W'(5));
        // Count to zero, then saturate
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, W'(5));
        // Zero load
        step(1'b1, 1'b0, W'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(0));
        // Reset mid-count with dec asserted across the reset edge
        step(1'b1, 1'b0, W'(5));
        step(1'b0, 1'b1, W'(5));
        step(1'b0, 1'b1, W'(5));
        step(1'b1, 1'b1, W'(7));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, W'(7));
        // Max value and load isolation
        step(1'b1, 1'b0, {W{1'b1}});
        step(1'b0, 1'b1, {W{1'b1}});
        step(1'b0, 1'b0, W'(3));
        step(1'b0, 1'b1, W'(0));
        // Random traffic: small loads so zero and saturation are reached often
        for (int i = 0; i < 600; i++) begin
            logic         r;
            logic         d;
            logic [W-1:0] v;
            r = ($urandom_range(0, 15) == 0);
            d = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)
                v = W'($urandom);
            else
                v = W'($urandom_range(0, 12));
            step(r, d, v);
        end

        begin
            int waited;
            waited = 0;
            while (sb_q.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (sb_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d entries left expected 0", sb_q.size());
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_num_counter

`default_nettype wire

// File: doc/num_counter.md
Name: num_counter

Overview:
- Loadable down-counter with zero detect. Used as a programmable delay or event counter: a terminal count is loaded at reset, the count decrements on each qualified cycle, and `isZero` flags exhaustion.
- Sits between control FSMs and the blocks they time. The owning FSM drives `dec` and watches `isZero`.

Parameters:
- WIDTH, 16, counter and load-value width in bits (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; loads the counter from inVal
- inVal  input  WIDTH  load value (terminal count), sampled only on a rising clk edge where rst=1
- dec  input  1  decrement enable, sampled on rising clk edge
- isZero  output  1  high when the current count equals 0
- count  output  WIDTH  current counter value (debug/observability; may be left unconnected)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous paths.
- State: one WIDTH-bit register `cnt`; `count` = `cnt`.
- Priority on each rising clk edge:
  1. rst=1: `cnt` <= inVal. `dec` is ignored.
  2. else if dec=1 and `cnt` != 0: `cnt` <= `cnt` - 1.
  3. else: `cnt` holds.
- Saturation: the counter never wraps. With dec=1 at `cnt`=0 it stays 0; no underflow to 2^WIDTH-1.
- isZero:
  - Combinational decode of the register: `isZero` = (`cnt` == 0). There are no combinational paths from inputs to outputs.
  - Latency: valid in the same cycle `cnt` changes, i.e. immediately after the edge that updates `cnt`.
- After reset with inVal=N:
  - exactly N edges with dec=1 (and rst=0) are needed for isZero to assert;
  - isZero stays high until the next reset.
- inVal=0 at reset: isZero high immediately after the reset edge.
- Reset mid-count: reloads inVal, discarding the remaining count. isZero reflects the new value after that edge.
- inVal changes while rst=0: no effect.
- Before the first reset edge, `cnt` and isZero are undefined (X in simulation). Users must reset before use.
- dec held high across the reset edge: reset wins. Decrementing starts on the first edge with rst=0.

Decomposition:
- Shared package: default WIDTH constant (COUNTER_W = 16) and a count_t typedef of that width, reused by FSMs that compute load values.
- No sub-module. A zero-detect comparator is inline logic and does not justify a separate block.
- Implementation includes parameter sanity checks (WIDTH >= 1) and simulation assertions:
  - no underflow;
  - isZero consistent with `count`;
  - `count` never increases except on reset.

Test Plan:
- Reset load and hold: inVal=5, dec=0, rst=1 for one edge, then two edges with rst=0, dec=0 -> count=5, isZero=0 throughout.
- Count to zero: after the above, dec=1 for 5 edges -> count 4,3,2,1,0. isZero goes to 1 only after the 5th edge.
- Saturation: continue dec=1 for 2 more edges -> count stays 0, isZero stays 1.
- Zero load: inVal=0, one reset edge -> isZero=1 immediately. Then dec=1 for 3 edges -> count remains 0.
- Reset mid-count and reset priority:
  - inVal=5, reset, 2 dec edges (count=3);
  - change inVal=7, assert rst together with dec=1 for one edge -> count=7, isZero=0;
  - then 7 dec edges -> isZero=1.
- Load isolation and max value:
  - WIDTH=16, inVal=16'hFFFF, reset, 1 dec edge -> count=16'hFFFE;
  - change inVal without rst -> count unaffected.
